// File: rtl/pokey_bus_arbiter.sv
// Round-robin arbiter that shares the POKEY CPU-side register port between
// several on-chip requesters and runs one phi2/cs0Bar bus cycle per grant.
module pokey_bus_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned PHI_LOW  = 2,
    parameter int unsigned PHI_HIGH = 3
) (
    input  logic              clk,
    input  logic              clrBar,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wr,
    input  logic [NREQ*4-1:0] addr,
    input  logic [NREQ*8-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic [3:0]        pokeyA,
    output logic [7:0]        pokeyDin,
    input  logic [7:0]        pokeyDout,
    output logic              pokeyPhi2,
    output logic              pokeyRHWL,
    output logic              pokeyCs0Bar
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [3:0]      a_q, a_d;
    logic [7:0]      din_q, din_d;
    logic            phi2_q, phi2_d;
    logic            rhwl_q, rhwl_d;
    logic            cs_q, cs_d;

    logic [IW-1:0]   win;
    logic [IW-1:0]   hi_idx, lo_idx;
    logic            hi_found;
    logic [3:0]      sel_addr;
    logic [7:0]      sel_wdata;
    logic            sel_wr;
    logic [NREQ-1:0] sel_onehot;

    // Round-robin pick: lowest pending index at/above rr, else lowest pending overall
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IW'(i);
                if (IW'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
        win = hi_found ? hi_idx : lo_idx;
    end

    // Operand mux for the selected requester
    always_comb begin
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_wr     = 1'b0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IW'(i) == win) begin
                sel_addr      = addr[i*4 +: 4];
                sel_wdata     = wdata[i*8 +: 8];
                sel_wr        = wr[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state and registered bus outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        a_d     = a_q;
        din_d   = din_q;
        phi2_d  = phi2_q;
        rhwl_d  = rhwl_q;
        cs_d    = cs_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = SETUP;
                    cnt_d   = CW'(PHI_LOW - 1);
                    idx_d   = win;
                    gnt_d   = sel_onehot;
                    a_d     = sel_addr;
                    din_d   = sel_wdata;
                    rhwl_d  = ~sel_wr;
                    cs_d    = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = CW'(PHI_HIGH - 1);
                    phi2_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    phi2_d  = 1'b0;
                    done_d  = gnt_q;
                    // POKEY drove Dout on the first phi2-high edge; it is settled by now
                    if (rhwl_q) begin
                        rdata_d = pokeyDout;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                state_d = IDLE;
                gnt_d   = '0;
                cs_d    = 1'b1;
                rhwl_d  = 1'b1;
                rr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge clrBar) begin
        if (!clrBar) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            a_q     <= '0;
            din_q   <= '0;
            phi2_q  <= 1'b0;
            rhwl_q  <= 1'b1;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            a_q     <= a_d;
            din_q   <= din_d;
            phi2_q  <= phi2_d;
            rhwl_q  <= rhwl_d;
            cs_q    <= cs_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign pokeyA      = a_q;
    assign pokeyDin    = din_q;
    assign pokeyPhi2   = phi2_q;
    assign pokeyRHWL   = rhwl_q;
    assign pokeyCs0Bar = cs_q;

endmodule

// File: tb/tb_pokey_bus_arbiter.sv
// Bench for pokey_bus_arbiter: default timing instance plus a PHI_LOW=1/PHI_HIGH=2
// instance, each attached to a small behavioural POKEY register model.
module tb_pokey_bus_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned L0 = 2;
    localparam int unsigned H0 = 3;
    localparam int unsigned L1 = 1;
    localparam int unsigned H1 = 2;

    logic clk = 1'b0;
    logic clrBar;

    logic [NREQ-1:0]   req_s   [2];
    logic [NREQ-1:0]   wr_s    [2];
    logic [NREQ*4-1:0] addr_s  [2];
    logic [NREQ*8-1:0] wdata_s [2];
    logic [NREQ-1:0]   gnt_s   [2];
    logic [NREQ-1:0]   done_s  [2];
    logic [7:0]        rdata_s [2];
    logic [3:0]        a_s     [2];
    logic [7:0]        din_s   [2];
    logic [7:0]        dout_s  [2];
    logic              phi2_s  [2];
    logic              rhwl_s  [2];
    logic              cs_s    [2];

    // POKEY model state
    logic [7:0]  preg [2][16] = '{default: '0};
    logic        phi2_prev [2] = '{default: 1'b0};
    logic [7:0]  rd_byte [2] = '{default: '0};
    int unsigned rise_cnt [2] = '{default: 0};
    logic [7:0]  rng_q = 8'h00;
    int unsigned cyc = 0;

    // Reference state
    int unsigned model_rr [2];
    logic [7:0]  exp_rdata [2];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pokey_bus_arbiter #(.NREQ(NREQ), .PHI_LOW(L0), .PHI_HIGH(H0)) u_dut0 (
        .clk(clk), .clrBar(clrBar), .req(req_s[0]), .wr(wr_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .gnt(gnt_s[0]), .done(done_s[0]), .rdata(rdata_s[0]),
        .pokeyA(a_s[0]), .pokeyDin(din_s[0]), .pokeyDout(dout_s[0]), .pokeyPhi2(phi2_s[0]),
        .pokeyRHWL(rhwl_s[0]), .pokeyCs0Bar(cs_s[0])
    );

    pokey_bus_arbiter #(.NREQ(NREQ), .PHI_LOW(L1), .PHI_HIGH(H1)) u_dut1 (
        .clk(clk), .clrBar(clrBar), .req(req_s[1]), .wr(wr_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .gnt(gnt_s[1]), .done(done_s[1]), .rdata(rdata_s[1]),
        .pokeyA(a_s[1]), .pokeyDin(din_s[1]), .pokeyDout(dout_s[1]), .pokeyPhi2(phi2_s[1]),
        .pokeyRHWL(rhwl_s[1]), .pokeyCs0Bar(cs_s[1])
    );

    // POKEY: acts on the clk edge where it first sees phi2 high; bus floats while phi2 low
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rng_q <= 8'($urandom);
        for (int u = 0; u < 2; u++) begin
            if (phi2_s[u] && !phi2_prev[u]) begin
                rise_cnt[u] <= rise_cnt[u] + 1;
                if (!cs_s[u]) begin
                    if (!rhwl_s[u]) begin
                        preg[u][a_s[u]] <= din_s[u];
                    end else begin
                        dout_s[u]  <= (a_s[u] == 4'hA) ? rng_q : preg[u][a_s[u]];
                        rd_byte[u] <= (a_s[u] == 4'hA) ? rng_q : preg[u][a_s[u]];
                    end
                end
            end else if (!phi2_s[u]) begin
                dout_s[u] <= 8'($urandom);
            end
            phi2_prev[u] <= phi2_s[u];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Round-robin rule: first pending requester at or after rr, modulo NREQ
    function automatic int pick(input logic [NREQ-1:0] r, input int unsigned rr);
        int j;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = (int'(rr) + k) % int'(NREQ);
            if (r[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        clrBar = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_s[u] = '0; wr_s[u] = '0; addr_s[u] = '0; wdata_s[u] = '0;
            model_rr[u] = 0; exp_rdata[u] = 8'h00;
        end
        repeat (2) tick();
        for (int u = 0; u < 2; u++) begin
            total++;
            if ({gnt_s[u], done_s[u], rdata_s[u], a_s[u], din_s[u], phi2_s[u], rhwl_s[u], cs_s[u]}
                !== {4'h0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1})
                $display("FAIL reset_values u%0d: gnt=%b done=%b rdata=%h A=%h Din=%h phi2=%b rhwl=%b cs=%b",
                         u, gnt_s[u], done_s[u], rdata_s[u], a_s[u], din_s[u], phi2_s[u], rhwl_s[u], cs_s[u]);
            else passed++;
        end
        clrBar = 1'b1;
        repeat (3) tick();
        total++;
        if (gnt_s[0] !== 4'h0 || cs_s[0] !== 1'b1 || phi2_s[0] !== 1'b0)
            $display("FAIL idle_no_req: gnt=%b cs=%b phi2=%b, expected 0000/1/0", gnt_s[0], cs_s[0], phi2_s[0]);
        else passed++;
    endtask

    task automatic test_single_write();
        int len = int'(L0 + H0 + 1);
        logic [NREQ-1:0] exp_oh, exp_g, exp_d;
        logic exp_p;
        exp_oh = onehot(pick(4'b0001, model_rr[0]));
        addr_s[0] = 16'($urandom); wdata_s[0] = 32'($urandom);
        addr_s[0][3:0] = 4'h1; wdata_s[0][7:0] = 8'hA8; wr_s[0] = 4'b0001;
        req_s[0] = 4'b0001;
        for (int s = 1; s <= len + 1; s++) begin
            tick();
            exp_g = (s <= len) ? exp_oh : 4'h0;
            exp_p = (s >= int'(L0) + 1) && (s <= int'(L0 + H0));
            exp_d = (s == len) ? exp_oh : 4'h0;
            total++;
            if (gnt_s[0] !== exp_g || phi2_s[0] !== exp_p || done_s[0] !== exp_d)
                $display("FAIL write_wave s=%0d: gnt=%b phi2=%b done=%b, expected gnt=%b phi2=%b done=%b",
                         s, gnt_s[0], phi2_s[0], done_s[0], exp_g, exp_p, exp_d);
            else passed++;
            if (s <= len) begin
                total++;
                if ({a_s[0], din_s[0], rhwl_s[0], cs_s[0]} !== {4'h1, 8'hA8, 1'b0, 1'b0})
                    $display("FAIL write_bus s=%0d: A=%h Din=%h rhwl=%b cs=%b, expected 1/a8/0/0",
                             s, a_s[0], din_s[0], rhwl_s[0], cs_s[0]);
                else passed++;
            end
            if (s == len) req_s[0] = '0;
        end
        total++;
        if (preg[0][1] !== 8'hA8) $display("FAIL write_lands: audc0=%h expected a8", preg[0][1]);
        else passed++;
        total++;
        if (rdata_s[0] !== exp_rdata[0])
            $display("FAIL write_keeps_rdata: rdata=%h expected %h", rdata_s[0], exp_rdata[0]);
        else passed++;
        model_rr[0] = 32'((pick(4'b0001, model_rr[0]) + 1) % int'(NREQ));
    endtask

    task automatic test_single_read();
        int len = int'(L0 + H0 + 1);
        logic [NREQ-1:0] exp_oh;
        exp_oh = onehot(pick(4'b0100, model_rr[0]));
        addr_s[0] = 16'($urandom); addr_s[0][11:8] = 4'hA;
        wr_s[0] = 4'b0000; req_s[0] = 4'b0100;
        for (int s = 1; s <= len + 1; s++) begin
            tick();
            if (s <= len) begin
                total++;
                if (rhwl_s[0] !== 1'b1 || gnt_s[0] !== exp_oh || a_s[0] !== 4'hA)
                    $display("FAIL read_bus s=%0d: rhwl=%b gnt=%b A=%h, expected 1/%b/a",
                             s, rhwl_s[0], gnt_s[0], a_s[0], exp_oh);
                else passed++;
            end
            if (s == int'(L0 + H0)) begin
                total++;
                if (rdata_s[0] !== exp_rdata[0])
                    $display("FAIL read_early s=%0d: rdata=%h expected %h", s, rdata_s[0], exp_rdata[0]);
                else passed++;
            end
            if (s == len) begin
                exp_rdata[0] = rd_byte[0];
                total++;
                if (done_s[0] !== exp_oh || rdata_s[0] !== exp_rdata[0])
                    $display("FAIL read_done s=%0d: done=%b rdata=%h, expected %b %h",
                             s, done_s[0], rdata_s[0], exp_oh, exp_rdata[0]);
                else passed++;
                req_s[0] = '0;
            end
        end
        total++;
        if (rdata_s[0] !== exp_rdata[0] || done_s[0] !== 4'h0)
            $display("FAIL read_hold: rdata=%h done=%b, expected %h 0000", rdata_s[0], done_s[0], exp_rdata[0]);
        else passed++;
        model_rr[0] = 32'((pick(4'b0100, model_rr[0]) + 1) % int'(NREQ));
    endtask

    task automatic test_req_drop();
        int len = int'(L0 + H0 + 1);
        logic [NREQ-1:0] exp_oh;
        logic [3:0] a3;
        logic [7:0] d3;
        exp_oh = onehot(pick(4'b1000, model_rr[0]));
        a3 = 4'($urandom);
        d3 = preg[0][a3] ^ 8'($urandom_range(1, 255));
        addr_s[0][15:12] = a3; wdata_s[0][31:24] = d3; wr_s[0] = 4'b1000;
        req_s[0] = 4'b1000;
        for (int s = 1; s <= len + 1; s++) begin
            tick();
            if (s <= len) begin
                total++;
                if (a_s[0] !== a3 || din_s[0] !== d3 || gnt_s[0] !== exp_oh)
                    $display("FAIL drop_bus s=%0d: A=%h Din=%h gnt=%b, expected %h %h %b",
                             s, a_s[0], din_s[0], gnt_s[0], a3, d3, exp_oh);
                else passed++;
            end
            if (s == int'(L0) + 1) begin
                req_s[0] = '0;
                addr_s[0][15:12] = ~a3; wdata_s[0][31:24] = ~d3; wr_s[0] = 4'b0000;
            end
            if (s == len) begin
                total++;
                if (done_s[0] !== exp_oh) $display("FAIL drop_done: done=%b expected %b", done_s[0], exp_oh);
                else passed++;
            end
        end
        total++;
        if (preg[0][a3] !== d3 || rdata_s[0] !== exp_rdata[0])
            $display("FAIL drop_lands: reg[%h]=%h rdata=%h, expected %h %h",
                     a3, preg[0][a3], rdata_s[0], d3, exp_rdata[0]);
        else passed++;
        model_rr[0] = 32'((pick(4'b1000, model_rr[0]) + 1) % int'(NREQ));
    endtask

    task automatic test_contention();
        int len = int'(L0 + H0 + 1);
        int k, hi, dpos, e;
        int unsigned last_start;
        logic [NREQ-1:0] exp_oh, dval;
        addr_s[0] = 16'($urandom); wdata_s[0] = 32'($urandom); wr_s[0] = 4'($urandom);
        req_s[0] = 4'hF;
        last_start = 0;
        for (int n = 0; n < 10; n++) begin
            e = pick(req_s[0], model_rr[0]);
            exp_oh = onehot(e);
            k = 0;
            while (gnt_s[0] === 4'h0 && k < 20) begin tick(); k++; end
            total++;
            if (gnt_s[0] !== exp_oh) $display("FAIL cont_grant n=%0d: gnt=%b expected %b", n, gnt_s[0], exp_oh);
            else passed++;
            if (n > 0) begin
                total++;
                if (cyc - last_start !== L0 + H0 + 2)
                    $display("FAIL cont_period n=%0d: period=%0d expected %0d", n, cyc - last_start, L0 + H0 + 2);
                else passed++;
            end
            last_start = cyc;
            hi = 0; dpos = 0; dval = '0;
            while (gnt_s[0] !== 4'h0 && hi < 20) begin
                if (done_s[0] !== 4'h0 && dpos == 0) begin dpos = hi + 1; dval = done_s[0]; end
                tick(); hi++;
            end
            total++;
            if (hi != len || dpos != len || dval !== exp_oh)
                $display("FAIL cont_txn n=%0d: gnt_cycles=%0d done_at=%0d done=%b, expected %0d %0d %b",
                         n, hi, dpos, dval, len, len, exp_oh);
            else passed++;
            model_rr[0] = 32'((e + 1) % int'(NREQ));
            if (n == 4) req_s[0][1] = 1'b0;
        end
        req_s[0] = '0;
    endtask

    task automatic test_reset_mid_strobe();
        int k, e;
        int unsigned rises;
        logic [NREQ-1:0] exp_oh;
        for (int i = 0; i < int'(NREQ); i++) begin
            addr_s[0][i*4 +: 4] = 4'($urandom); wdata_s[0][i*8 +: 8] = 8'($urandom);
        end
        wr_s[0] = 4'hF; req_s[0] = 4'b1010;
        exp_oh = onehot(pick(4'b1010, model_rr[0]));
        k = 0;
        while (gnt_s[0] === 4'h0 && k < 20) begin tick(); k++; end
        total++;
        if (gnt_s[0] !== exp_oh) $display("FAIL rst_pre_grant: gnt=%b expected %b", gnt_s[0], exp_oh);
        else passed++;
        k = 0;
        while (phi2_s[0] !== 1'b1 && k < 20) begin tick(); k++; end
        tick();
        total++;
        if (phi2_s[0] !== 1'b1) $display("FAIL rst_pre_phi2: phi2=%b expected 1", phi2_s[0]);
        else passed++;
        rises = rise_cnt[0];
        clrBar = 1'b0;
        #1;
        total++;
        if ({gnt_s[0], done_s[0], phi2_s[0], rhwl_s[0], cs_s[0], rdata_s[0]} !== {4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 8'h00})
            $display("FAIL rst_immediate: gnt=%b done=%b phi2=%b rhwl=%b cs=%b rdata=%h, expected 0000 0000 0 1 1 00",
                     gnt_s[0], done_s[0], phi2_s[0], rhwl_s[0], cs_s[0], rdata_s[0]);
        else passed++;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (gnt_s[0] !== 4'h0 || done_s[0] !== 4'h0 || phi2_s[0] !== 1'b0)
                $display("FAIL rst_held c=%0d: gnt=%b done=%b phi2=%b, expected 0000 0000 0", c, gnt_s[0], done_s[0], phi2_s[0]);
            else passed++;
        end
        clrBar = 1'b1;
        for (int u = 0; u < 2; u++) begin model_rr[u] = 0; exp_rdata[u] = 8'h00; end
        e = pick(req_s[0], model_rr[0]);
        exp_oh = onehot(e);
        k = 0;
        while (gnt_s[0] === 4'h0 && k < 20) begin tick(); k++; end
        total++;
        if (gnt_s[0] !== exp_oh) $display("FAIL rst_post_grant: gnt=%b expected %b", gnt_s[0], exp_oh);
        else passed++;
        total++;
        if (rise_cnt[0] !== rises) $display("FAIL rst_no_rise: rises=%0d expected %0d", rise_cnt[0], rises);
        else passed++;
        k = 0;
        while (gnt_s[0] !== 4'h0 && k < 20) begin tick(); k++; end
        req_s[0] = '0;
        model_rr[0] = 32'((e + 1) % int'(NREQ));
    endtask

    task automatic test_back_to_back();
        int len = int'(L1 + H1 + 1);
        int k, hi, dpos, e;
        int unsigned last_start, rises0;
        logic [NREQ-1:0] exp_oh, dval;
        logic [3:0] a_exp;
        logic [7:0] d_exp;
        for (int i = 0; i < int'(NREQ); i++) begin
            addr_s[1][i*4 +: 4] = 4'($urandom);
            wdata_s[1][i*8 +: 8] = preg[1][addr_s[1][i*4 +: 4]] ^ 8'($urandom_range(1, 255));
        end
        wr_s[1] = 4'hF;
        req_s[1] = 4'($urandom_range(1, 15));
        last_start = 0;
        for (int n = 0; n < 8; n++) begin
            e = pick(req_s[1], model_rr[1]);
            exp_oh = onehot(e);
            a_exp = addr_s[1][e*4 +: 4];
            d_exp = wdata_s[1][e*8 +: 8];
            rises0 = rise_cnt[1];
            k = 0;
            while (gnt_s[1] === 4'h0 && k < 20) begin tick(); k++; end
            total++;
            if (gnt_s[1] !== exp_oh) $display("FAIL b2b_grant n=%0d: gnt=%b expected %b", n, gnt_s[1], exp_oh);
            else passed++;
            if (n > 0) begin
                total++;
                if (cyc - last_start !== L1 + H1 + 2)
                    $display("FAIL b2b_period n=%0d: period=%0d expected %0d", n, cyc - last_start, L1 + H1 + 2);
                else passed++;
            end
            last_start = cyc;
            hi = 0; dpos = 0; dval = '0;
            while (gnt_s[1] !== 4'h0 && hi < 20) begin
                if (done_s[1] !== 4'h0 && dpos == 0) begin dpos = hi + 1; dval = done_s[1]; end
                tick(); hi++;
            end
            total++;
            if (hi != len || dpos != len || dval !== exp_oh)
                $display("FAIL b2b_txn n=%0d: gnt_cycles=%0d done_at=%0d done=%b, expected %0d %0d %b",
                         n, hi, dpos, dval, len, len, exp_oh);
            else passed++;
            total++;
            if (rise_cnt[1] !== rises0 + 1)
                $display("FAIL b2b_one_rise n=%0d: rises=%0d expected %0d", n, rise_cnt[1] - rises0, 1);
            else passed++;
            total++;
            if (preg[1][a_exp] !== d_exp)
                $display("FAIL b2b_lands n=%0d: reg[%h]=%h expected %h", n, a_exp, preg[1][a_exp], d_exp);
            else passed++;
            model_rr[1] = 32'((e + 1) % int'(NREQ));
            addr_s[1][e*4 +: 4] = 4'($urandom);
            wdata_s[1][e*8 +: 8] = preg[1][addr_s[1][e*4 +: 4]] ^ 8'($urandom_range(1, 255));
        end
        req_s[1] = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_req_drop();
        test_contention();
        test_reset_mid_strobe();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
